// File: rtl/apb_master_pkg.sv
// Shared types for the APB requester: FSM state encoding and the captured command.
package apb_master_pkg;
  localparam int ADDR_W_DFLT = 32;
  localparam int DATA_W_DFLT = 32;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  typedef struct packed {
    logic                   write;
    logic [ADDR_W_DFLT-1:0] addr;
    logic [DATA_W_DFLT-1:0] wdata;
  } cmd_t;
endpackage

// File: rtl/apb_master_if.sv
// Command/response handshake plus APB bus signals of the requester.
interface apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata, prdata;
  logic              pready, pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB requester (IDLE/SETUP/ACCESS/RESP).
// Define APB_MASTER_TIMEOUT_EN to add an ACCESS-phase watchdog of TIMEOUT_CYC cycles.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DFLT,
  parameter int DATA_W      = DATA_W_DFLT,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 pclk,
  input  logic                 presetn,
  apb_master_if.master         bus
);

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: if (bus.req_valid) begin
        cmd_d.write = bus.req_write;
        cmd_d.addr  = ADDR_W_DFLT'(bus.req_addr);
        cmd_d.wdata = DATA_W_DFLT'(bus.req_wdata);
        state_d     = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ACCESS: begin
        // prdata/pslverr only matter on the completing edge
        if (bus.pready) begin
          rdata_d = cmd_q.write ? '0 : bus.prdata;
          err_d   = bus.pslverr;
          state_d = RESP;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Bus fields come straight from the captured command so they hold between transfers
  assign bus.req_ready = presetn && (state_q == IDLE);
  assign bus.psel      = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.penable   = (state_q == ACCESS);
  assign bus.pwrite    = cmd_q.write;
  assign bus.paddr     = cmd_q.addr[ADDR_W-1:0];
  assign bus.pwdata    = cmd_q.wdata[DATA_W-1:0];
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule
